fifo_word_packer: RTL and testbench

FIFO_WORD_PACKER -- requirements
Module: fifo_word_packer

---
 rtl/fifo_pkg.sv | 14 +
 rtl/fifo_word_packer_if.sv | 27 ++
 rtl/pack_out_reg.sv | 51 +++++
 rtl/fifo_word_packer.sv | 117 +++++++++++
 tb/tb_fifo_word_packer.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/fifo_pkg.sv
// Shared constants and state encoding for the FIFO word packer.
// The byte counter is fixed at 3 bits because only 4-byte words are supported.
package fifo_pkg;
   localparam int FIFO_WIDTH      = 8;
   localparam int FIFO_DEPTH      = 16;
   localparam int PACK_WORD_BYTES = 4;
   localparam int CNT_W           = 3;

   typedef enum logic [1:0] {
      ST_FILL       = 2'd0,
      ST_FLUSH_WAIT = 2'd1,
      ST_EMIT       = 2'd2
   } pack_state_e;
endpackage

// File: rtl/fifo_word_packer_if.sv
// FIFO read side and packed-word output side of the packer.
// master = the packer itself, slave = the FIFO/consumer environment.
interface fifo_word_packer_if
   import fifo_pkg::*;
#(
   parameter int BYTE_WIDTH = FIFO_WIDTH,
   parameter int WORD_BYTES = PACK_WORD_BYTES
);
   logic [BYTE_WIDTH-1:0]            fifo_data;
   logic                             fifo_empty;
   logic                             fifo_read_n;
   logic                             flush;
   logic [BYTE_WIDTH*WORD_BYTES-1:0] word_out;
   logic [WORD_BYTES-1:0]            word_keep;
   logic                             word_valid;
   logic                             out_ready;

   modport master (
      input  fifo_data, fifo_empty, flush, out_ready,
      output fifo_read_n, word_out, word_keep, word_valid
   );

   modport slave (
      output fifo_data, fifo_empty, flush, out_ready,
      input  fifo_read_n, word_out, word_keep, word_valid
   );
endinterface

// File: rtl/pack_out_reg.sv
// Output valid/ready holding register: a new load may replace a word in the
// same cycle it is accepted, so back-to-back words carry no bubble.
module pack_out_reg
   import fifo_pkg::*;
#(
   parameter int WORD_W = FIFO_WIDTH * PACK_WORD_BYTES,
   parameter int KEEP_W = PACK_WORD_BYTES
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              load_i,
   input  logic [WORD_W-1:0] word_i,
   input  logic [KEEP_W-1:0] keep_i,
   input  logic              ready_i,
   output logic              valid_o,
   output logic [WORD_W-1:0] word_o,
   output logic [KEEP_W-1:0] keep_o
);
   logic              valid_q, valid_d;
   logic [WORD_W-1:0] word_q, word_d;
   logic [KEEP_W-1:0] keep_q, keep_d;

   always_comb begin
      valid_d = valid_q;
      word_d  = word_q;
      keep_d  = keep_q;
      if (load_i) begin
         valid_d = 1'b1;
         word_d  = word_i;
         keep_d  = keep_i;
      end else if (ready_i) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clock) begin
      if (reset_n) begin
         valid_q <= 1'b0;
         word_q  <= '0;
         keep_q  <= '0;
      end else begin
         valid_q <= valid_d;
         word_q  <= word_d;
         keep_q  <= keep_d;
      end
   end

   assign valid_o = valid_q;
   assign word_o  = word_q;
   assign keep_o  = keep_q;
endmodule

// File: rtl/fifo_word_packer.sv
// Reads bytes from a FIFO and packs them little-endian into 4-byte words,
// with flush support for emitting a partial word. reset_n is active-high.
module fifo_word_packer
   import fifo_pkg::*;
#(
   parameter int BYTE_WIDTH = FIFO_WIDTH,
   parameter int WORD_BYTES = PACK_WORD_BYTES
) (
   input  logic               clock,
   input  logic               reset_n,
   fifo_word_packer_if.master bus
);
   localparam int              WORD_W   = BYTE_WIDTH * WORD_BYTES;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(WORD_BYTES);

   pack_state_e                          state_q, state_d;
   logic [CNT_W-1:0]                     byte_cnt_q, byte_cnt_d, cnt_m;
   logic                                 rd_inflight_q, flush_pend_q, flush_pend_d;
   logic [WORD_BYTES-1:0][BYTE_WIDTH-1:0] acc_q, acc_m;
   logic                                 rd_en, out_free, load;
   logic [WORD_BYTES-1:0]                load_keep;
   logic [WORD_W-1:0]                    load_word;
   logic                                 word_valid;
   logic [WORD_W-1:0]                    word_out;
   logic [WORD_BYTES-1:0]                word_keep;

   // acc_m/cnt_m already include the byte arriving this cycle, so a word that
   // completes now can be loaded at the same edge (2-cycle strobe-to-valid).
   assign cnt_m    = byte_cnt_q + {{(CNT_W-1){1'b0}}, rd_inflight_q};
   assign out_free = !word_valid || bus.out_ready;
   assign rd_en    = !reset_n && !bus.fifo_empty && (state_q == ST_FILL)
                     && !flush_pend_q && (cnt_m < FULL_CNT);
   assign bus.fifo_read_n = !rd_en;

   for (genvar gi = 0; gi < WORD_BYTES; gi++) begin : g_lane
      assign acc_m[gi] = (rd_inflight_q && (byte_cnt_q == CNT_W'(gi)))
                         ? bus.fifo_data : acc_q[gi];
      assign load_keep[gi] = (CNT_W'(gi) < cnt_m);
      assign load_word[gi*BYTE_WIDTH +: BYTE_WIDTH] = load_keep[gi] ? acc_m[gi] : '0;
   end

   always_comb begin
      state_d      = state_q;
      byte_cnt_d   = cnt_m;
      flush_pend_d = flush_pend_q | (bus.flush && (state_q != ST_FILL));
      load         = 1'b0;
      unique case (state_q)
         ST_FILL: begin
            if (cnt_m == FULL_CNT) begin
               if (out_free) begin
                  load       = 1'b1;
                  byte_cnt_d = '0;
               end else begin
                  state_d = ST_EMIT;
               end
            end else if (bus.flush) begin
               state_d      = ST_FLUSH_WAIT;
               flush_pend_d = 1'b1;
            end
         end
         ST_FLUSH_WAIT: begin
            if (!rd_inflight_q) begin
               if (byte_cnt_q != '0) begin
                  state_d = ST_EMIT;
               end else begin
                  state_d      = ST_FILL;
                  flush_pend_d = 1'b0;
               end
            end
         end
         ST_EMIT: begin
            if (out_free) begin
               load         = 1'b1;
               byte_cnt_d   = '0;
               flush_pend_d = 1'b0;
               state_d      = ST_FILL;
            end
         end
         default: state_d = ST_FILL;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset_n) begin
         state_q       <= ST_FILL;
         byte_cnt_q    <= '0;
         rd_inflight_q <= 1'b0;
         flush_pend_q  <= 1'b0;
         acc_q         <= '0;
      end else begin
         state_q       <= state_d;
         byte_cnt_q    <= byte_cnt_d;
         rd_inflight_q <= rd_en;
         flush_pend_q  <= flush_pend_d;
         acc_q         <= acc_m;
      end
   end

   pack_out_reg #(
      .WORD_W (WORD_W),
      .KEEP_W (WORD_BYTES)
   ) u_out (
      .clock   (clock),
      .reset_n (reset_n),
      .load_i  (load),
      .word_i  (load_word),
      .keep_i  (load_keep),
      .ready_i (bus.out_ready),
      .valid_o (word_valid),
      .word_o  (word_out),
      .keep_o  (word_keep)
   );

   assign bus.word_valid = word_valid;
   assign bus.word_out   = word_out;
   assign bus.word_keep  = word_keep;
endmodule

// File: tb/tb_fifo_word_packer.sv
// Directed and randomized bench for fifo_word_packer with a byte-stream
// reference model (bytes grouped in read order, closed at 4 bytes or on flush).
module tb_fifo_word_packer;
   import fifo_pkg::*;

   typedef struct {
      logic [31:0] word;
      logic [3:0]  keep;
   } exp_t;

   logic clock;
   logic reset_n;
   fifo_word_packer_if bus ();

   fifo_word_packer dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   logic [7:0] fifo_q[$];
   logic [7:0] pend_q[$];
   exp_t       exp_q[$];
   int n_cmp = 0;
   int n_err = 0;
   int cyc = 0;
   int strobe_cnt, first_strobe, last_strobe, valid_cnt, first_valid;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic clr_stats();
      strobe_cnt   = 0;
      first_strobe = -1;
      last_strobe  = -1;
      valid_cnt    = 0;
      first_valid  = -1;
   endtask

   function automatic void close_word();
      exp_t e;
      e.word = '0;
      e.keep = 4'((1 << pend_q.size()) - 1);
      foreach (pend_q[i]) e.word = e.word | (32'(pend_q[i]) << (8 * i));
      exp_q.push_back(e);
      pend_q.delete();
   endfunction

   // One clock: inputs already driven; sample at negedge, update FIFO after posedge.
   task automatic cycle();
      logic [7:0] popped;
      logic       got_pop;
      popped  = '0;
      got_pop = 1'b0;
      bus.fifo_empty = (fifo_q.size() == 0);
      @(negedge clock);
      if (reset_n) begin
         chk("rst_read_n", 64'(bus.fifo_read_n), 64'd1);
         pend_q.delete();
         exp_q.delete();
      end else begin
         cyc++;
         if (bus.fifo_empty) chk("read_while_empty", 64'(bus.fifo_read_n), 64'd1);
         if (bus.word_valid) begin
            valid_cnt++;
            if (first_valid < 0) first_valid = cyc;
            if (exp_q.size() == 0) begin
               chk("word_unexpected", 64'(bus.word_valid), 64'd0);
            end else begin
               chk("word_out", 64'(bus.word_out), 64'(exp_q[0].word));
               chk("word_keep", 64'(bus.word_keep), 64'(exp_q[0].keep));
               if (bus.out_ready) begin
                  $display("[%0t] word %08h keep %h accepted", $time, bus.word_out, bus.word_keep);
                  void'(exp_q.pop_front());
               end
            end
         end
         if (!bus.fifo_read_n) begin
            strobe_cnt++;
            if (first_strobe < 0) first_strobe = cyc;
            last_strobe = cyc;
            if (fifo_q.size() > 0) begin
               popped  = fifo_q.pop_front();
               got_pop = 1'b1;
               pend_q.push_back(popped);
               if (pend_q.size() == 4) close_word();
            end
         end
         if (bus.flush && pend_q.size() > 0) close_word();
      end
      @(posedge clock);
      #1;
      if (got_pop) bus.fifo_data = popped;
      bus.flush = 1'b0;
   endtask

   task automatic drain();
      bus.out_ready = 1'b1;
      for (int i = 0; i < 200; i++) begin
         if (i >= 8 && fifo_q.size() == 0 && pend_q.size() == 0 && exp_q.size() == 0) break;
         if (fifo_q.size() == 0 && pend_q.size() > 0 && (i % 4) == 0) bus.flush = 1'b1;
         cycle();
      end
      chk("drain_left", 64'(exp_q.size() + pend_q.size() + fifo_q.size()), 64'd0);
   endtask

   initial begin
      bus.fifo_data  = '0;
      bus.fifo_empty = 1'b1;
      bus.flush      = 1'b0;
      bus.out_ready  = 1'b1;
      reset_n        = 1'b1;
      clr_stats();
      @(posedge clock);
      #1;

      // Reset with a byte waiting: no strobe during reset, clean outputs after.
      fifo_q.push_back(8'h99);
      repeat (3) cycle();
      reset_n = 1'b0;
      chk("rst_valid", 64'(bus.word_valid), 64'd0);
      chk("rst_word", 64'(bus.word_out), 64'd0);
      chk("rst_keep", 64'(bus.word_keep), 64'd0);
      drain();

      // Four bytes back to back: one full word, 2-cycle latency.
      clr_stats();
      fifo_q = '{8'h11, 8'h22, 8'h33, 8'h44};
      repeat (10) cycle();
      chk("t1_strobes", 64'(strobe_cnt), 64'd4);
      chk("t1_back_to_back", 64'(last_strobe - first_strobe), 64'd3);
      chk("t1_latency", 64'(first_valid - last_strobe), 64'd2);
      chk("t1_valid_cycles", 64'(valid_cnt), 64'd1);

      // Two bytes then flush: partial word, no read while empty.
      clr_stats();
      fifo_q = '{8'hA1, 8'hA2};
      repeat (4) cycle();
      bus.flush = 1'b1;
      repeat (8) cycle();
      chk("t2_strobes", 64'(strobe_cnt), 64'd2);
      chk("t2_valid_cycles", 64'(valid_cnt), 64'd1);

      // Backpressure: reads stop with one word held and one accumulated.
      clr_stats();
      bus.out_ready = 1'b0;
      for (int i = 1; i <= 12; i++) fifo_q.push_back(8'(i));
      repeat (16) cycle();
      chk("t3_strobes", 64'(strobe_cnt), 64'd8);
      chk("t3_fifo_left", 64'(fifo_q.size()), 64'd4);
      chk("t3_held_word", 64'(bus.word_out), 64'h04030201);
      bus.out_ready = 1'b1;
      cycle();
      chk("t3_nobubble_valid", 64'(bus.word_valid), 64'd1);
      chk("t3_second_word", 64'(bus.word_out), 64'h08070605);
      drain();

      // Flush in the same cycle as the read strobe of 0x5C.
      clr_stats();
      fifo_q.push_back(8'h5C);
      bus.flush = 1'b1;
      repeat (8) cycle();
      chk("t4_strobes", 64'(strobe_cnt), 64'd1);
      chk("t4_valid_cycles", 64'(valid_cnt), 64'd1);

      // Reset with 3 bytes held and 1 in flight; next 4 bytes form a clean word.
      clr_stats();
      fifo_q = '{8'h10, 8'h20, 8'h30, 8'h40};
      repeat (4) cycle();
      reset_n = 1'b1;
      cycle();
      reset_n = 1'b0;
      chk("t5_valid", 64'(bus.word_valid), 64'd0);
      chk("t5_byte_cnt", 64'(dut.byte_cnt_q), 64'd0);
      chk("t5_inflight", 64'(dut.rd_inflight_q), 64'd0);
      clr_stats();
      fifo_q = '{8'h51, 8'h52, 8'h53, 8'h54};
      repeat (8) cycle();
      chk("t5_strobes", 64'(strobe_cnt), 64'd4);
      chk("t5_valid_cycles", 64'(valid_cnt), 64'd1);

      // Random traffic, backpressure and flushes.
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 99) < 45 && fifo_q.size() < FIFO_DEPTH)
            fifo_q.push_back(8'($urandom));
         bus.out_ready = ($urandom_range(0, 3) != 0);
         bus.flush     = ($urandom_range(0, 19) == 0);
         cycle();
      end
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
